// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register mask from the lowest to the highest
// register and performs one memory access per set bit, with memory ready
// handshake, register write-back for loads and an end-address result.
module ldm_stm_sequencer #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              isLoad,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [NREGS-1:0]  regMask,
    input  logic              memReady,
    input  logic [DATA_W-1:0] memRdData,
    input  logic [DATA_W-1:0] regRdData,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWrData,
    output logic              memRead,
    output logic              memWrite,
    output logic [IDX_W-1:0]  regIdx,
    output logic [DATA_W-1:0] regWrData,
    output logic              regWrite,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] finalAddr
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        ACCESS = 3'd2,
        WBACK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state,      state_d;
    logic               is_load,    is_load_d;
    logic [ADDR_W-1:0]  cur_addr,   cur_addr_d;
    logic [NREGS-1:0]   pending,    pending_d;
    logic [IDX_W-1:0]   reg_idx,    reg_idx_d;
    logic [DATA_W-1:0]  wr_data,    wr_data_d;
    logic [ADDR_W-1:0]  final_addr, final_addr_d;
    logic               retire;

    // Index of the lowest set bit; scanning downward lets the lowest win.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NREGS-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(NREGS) - 1; i >= 0; i--) begin
            if (m[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            is_load    <= 1'b0;
            cur_addr   <= '0;
            pending    <= '0;
            reg_idx    <= '0;
            wr_data    <= '0;
            final_addr <= '0;
        end else begin
            state      <= state_d;
            is_load    <= is_load_d;
            cur_addr   <= cur_addr_d;
            pending    <= pending_d;
            reg_idx    <= reg_idx_d;
            wr_data    <= wr_data_d;
            final_addr <= final_addr_d;
        end
    end

    // Next-state, datapath next values and Moore control outputs.
    always_comb begin
        state_d      = state;
        is_load_d    = is_load;
        cur_addr_d   = cur_addr;
        pending_d    = pending;
        reg_idx_d    = reg_idx;
        wr_data_d    = wr_data;
        final_addr_d = final_addr;
        retire       = 1'b0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        regWrite     = 1'b0;
        done         = 1'b0;
        busy         = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    is_load_d  = isLoad;
                    cur_addr_d = baseAddr;
                    pending_d  = regMask;
                    if (regMask != '0) begin
                        state_d = SCAN;
                    end else begin
                        state_d      = DONE;
                        final_addr_d = baseAddr;
                    end
                end
            end
            SCAN: begin
                reg_idx_d = lowest_set(pending);
                state_d   = ACCESS;
            end
            ACCESS: begin
                memRead  = is_load;
                memWrite = ~is_load;
                if (memReady) begin
                    if (is_load) begin
                        wr_data_d = memRdData;
                        state_d   = WBACK;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            WBACK: begin
                regWrite = 1'b1;
                retire   = 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Retire the current register and step to the next address.
        if (retire) begin
            pending_d[reg_idx] = 1'b0;
            cur_addr_d         = cur_addr + ADDR_W'(1);
            if (pending_d != '0) begin
                state_d = SCAN;
            end else begin
                state_d      = DONE;
                final_addr_d = cur_addr_d;
            end
        end
    end

    assign memAddr   = cur_addr;
    assign regIdx    = reg_idx;
    assign regWrData = wr_data;
    assign finalAddr = final_addr;

    // Store data passes straight through from the register file.
    assign memWrData = memWrite ? regRdData : '0;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: expected accesses, write-backs and
// end addresses are queued when an operation starts and popped as they occur.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        isLoad = 1'b0;
    logic [11:0] baseAddr = '0;
    logic [7:0]  regMask = '0;
    logic        memReady;
    logic [15:0] memRdData;
    logic [15:0] regRdData;
    logic [11:0] memAddr;
    logic [15:0] memWrData;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  regIdx;
    logic [15:0] regWrData;
    logic        regWrite;
    logic        busy;
    logic        done;
    logic [11:0] finalAddr;

    typedef struct packed {
        logic        wr;
        logic [11:0] addr;
        logic [2:0]  idx;
        logic [15:0] data;
    } acc_t;

    typedef struct packed {
        logic [2:0]  idx;
        logic [15:0] data;
    } wb_t;

    acc_t        acc_q[$];
    wb_t         wb_q[$];
    logic [11:0] done_q[$];

    logic [15:0] mem [4096];
    logic [15:0] regfile [8];

    int   checks = 0;
    int   errors = 0;
    int   wait_target = 0;
    logic force_ready = 1'b0;
    int   exp_hold = 1;
    int   wait_cnt = 0;
    int   run = 0;

    ldm_stm_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .isLoad    (isLoad),
        .baseAddr  (baseAddr),
        .regMask   (regMask),
        .memReady  (memReady),
        .memRdData (memRdData),
        .regRdData (regRdData),
        .memAddr   (memAddr),
        .memWrData (memWrData),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .regIdx    (regIdx),
        .regWrData (regWrData),
        .regWrite  (regWrite),
        .busy      (busy),
        .done      (done),
        .finalAddr (finalAddr)
    );

    always #5 clk = ~clk;

    // Memory and register-file models.
    assign regRdData = regfile[regIdx];
    assign memRdData = memRead ? mem[memAddr] : 16'h0;
    assign memReady  = force_ready | ((memRead | memWrite) && (wait_cnt == wait_target));

    // Wait-state counter for the memory model.
    always @(posedge clk) begin
        if ((memRead | memWrite) && !memReady) wait_cnt <= wait_cnt + 1;
        else                                   wait_cnt <= 0;
    end

    // Monitor: compare completed accesses, write-backs and completions.
    always @(negedge clk) begin
        acc_t        ea;
        wb_t         ew;
        logic [11:0] ef;
        if (memRead && memWrite) begin
            checks++; errors++;
            $display("FAIL rw_exclusive: memRead and memWrite both high at %0t", $time);
        end
        if (!memWrite) begin
            checks++;
            if (memWrData !== 16'h0) begin
                errors++;
                $display("FAIL wrdata_idle: got %h want 0000", memWrData);
            end
        end
        if (memRead || memWrite) begin
            run++;
            if (memReady) begin
                checks++;
                if (acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_access: addr %h idx %0d wr %b", memAddr, regIdx, memWrite);
                end else begin
                    ea = acc_q.pop_front();
                    if (memWrite !== ea.wr || memAddr !== ea.addr || regIdx !== ea.idx ||
                        (ea.wr && memWrData !== ea.data)) begin
                        errors++;
                        $display("FAIL access: got wr %b addr %h idx %0d data %h want wr %b addr %h idx %0d data %h",
                                 memWrite, memAddr, regIdx, memWrData, ea.wr, ea.addr, ea.idx, ea.data);
                    end
                end
                checks++;
                if (run !== exp_hold) begin
                    errors++;
                    $display("FAIL request_hold: got %0d cycles want %0d", run, exp_hold);
                end
                run = 0;
            end
        end else begin
            run = 0;
        end
        if (regWrite) begin
            checks++;
            if (wb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_regwrite: idx %0d data %h", regIdx, regWrData);
            end else begin
                ew = wb_q.pop_front();
                if (regIdx !== ew.idx || regWrData !== ew.data) begin
                    errors++;
                    $display("FAIL regwrite: got idx %0d data %h want idx %0d data %h",
                             regIdx, regWrData, ew.idx, ew.data);
                end
            end
        end
        if (done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: finalAddr %h", finalAddr);
            end else begin
                ef = done_q.pop_front();
                if (finalAddr !== ef) begin
                    errors++;
                    $display("FAIL final_addr: got %h want %h", finalAddr, ef);
                end
            end
        end
    end

    // Drive a start request and queue everything the operation should produce.
    task automatic start_op(input logic ld, input logic [11:0] base, input logic [7:0] mask,
                            input int wt, input logic fr);
        int          k;
        logic [11:0] a;
        acc_t        e;
        wb_t         w;
        @(posedge clk); #1;
        wait_target = wt;
        force_ready = fr;
        exp_hold    = fr ? 1 : wt + 1;
        isLoad      = ld;
        baseAddr    = base;
        regMask     = mask;
        start       = 1'b1;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                a      = base + 12'(k);
                e.wr   = ~ld;
                e.addr = a;
                e.idx  = 3'(i);
                e.data = ld ? mem[a] : regfile[i];
                acc_q.push_back(e);
                if (ld) begin
                    w.idx  = 3'(i);
                    w.data = mem[a];
                    wb_q.push_back(w);
                end
                k++;
            end
        end
        done_q.push_back(base + 12'(k));
    endtask

    // Step until done, bounded; returns cycles counted from the start edge.
    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({memRead, memWrite, regWrite, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {memRead, memWrite, regWrite, busy, done});
        end
        checks++;
        if (memAddr !== 12'h0 || finalAddr !== 12'h0 || regIdx !== 3'h0) begin
            errors++;
            $display("FAIL reset_addr: memAddr %h finalAddr %h regIdx %0d want 0", memAddr, finalAddr, regIdx);
        end
        checks++;
        if (regWrData !== 16'h0 || memWrData !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: regWrData %h memWrData %h want 0", regWrData, memWrData);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_stm_basic;
        int cyc; bit ok;
        start_op(1'b0, 12'h010, 8'b0000_0101, 0, 1'b1);
        wait_done(cyc, ok);
        checks++;
        if (!ok || cyc != 5) begin
            errors++;
            $display("FAIL stm_latency: got %0d cycles (done %b) want 5", cyc, ok);
        end
        checks++;
        if (finalAddr !== 12'h012) begin
            errors++;
            $display("FAIL stm_final: got %h want 012", finalAddr);
        end
    endtask

    task automatic test_ldm_wait;
        int cyc; bit ok;
        start_op(1'b1, 12'h0FF, 8'b1000_0001, 2, 1'b0);
        wait_done(cyc, ok);
        checks++;
        if (!ok || cyc != 11) begin
            errors++;
            $display("FAIL ldm_latency: got %0d cycles (done %b) want 11", cyc, ok);
        end
        checks++;
        if (finalAddr !== 12'h101) begin
            errors++;
            $display("FAIL ldm_final: got %h want 101", finalAddr);
        end
    endtask

    task automatic test_empty_mask;
        int cyc; bit ok;
        start_op(1'b1, 12'h5A5, 8'h00, 0, 1'b1);
        wait_done(cyc, ok);
        checks++;
        if (!ok || cyc != 1) begin
            errors++;
            $display("FAIL empty_latency: got %0d cycles (done %b) want 1", cyc, ok);
        end
        checks++;
        if (finalAddr !== 12'h5A5) begin
            errors++;
            $display("FAIL empty_final: got %h want 5a5", finalAddr);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_pulse: done %b busy %b want 0 0", done, busy);
        end
    endtask

    task automatic test_wrap;
        int cyc; bit ok;
        start_op(1'b0, 12'hFFF, 8'h03, 0, 1'b1);
        wait_done(cyc, ok);
        checks++;
        if (!ok || cyc != 5 || finalAddr !== 12'h001) begin
            errors++;
            $display("FAIL wrap: got %0d cycles final %h want 5 cycles final 001", cyc, finalAddr);
        end
    endtask

    task automatic test_start_ignored;
        int cyc;
        bit ok;
        start_op(1'b1, 12'h200, 8'h5A, 2, 1'b0);
        cyc = 0;
        ok  = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == 3);
            if (cyc == 3) begin
                isLoad   = 1'b0;
                baseAddr = 12'h000;
                regMask  = 8'hFF;
                checks++;
                if (memRead !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ignore_setup: memRead %b busy %b want 1 1", memRead, busy);
                end
            end
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (!ok || cyc != 21) begin
            errors++;
            $display("FAIL ignore_latency: got %0d cycles (done %b) want 21", cyc, ok);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_queued: busy %b want 0", busy);
        end
    endtask

    task automatic test_reset_abort;
        int cyc; bit ok;
        start_op(1'b1, 12'h300, 8'h03, 3, 1'b0);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (memRead !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: memRead %b want 1", memRead);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({memRead, memWrite, regWrite, busy, done} !== 5'b0 || memAddr !== 12'h0 || regWrData !== 16'h0) begin
            errors++;
            $display("FAIL abort_outputs: ctrl %b memAddr %h regWrData %h want 0",
                     {memRead, memWrite, regWrite, busy, done}, memAddr, regWrData);
        end
        acc_q.delete();
        wb_q.delete();
        done_q.delete();
        repeat (4) begin
            @(posedge clk); #1;
            checks++;
            if (regWrite !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: regWrite %b busy %b want 0 0", regWrite, busy);
            end
        end
        rst = 1'b1;
        start_op(1'b0, 12'h040, 8'h81, 0, 1'b1);
        wait_done(cyc, ok);
        checks++;
        if (!ok || cyc != 5 || finalAddr !== 12'h042) begin
            errors++;
            $display("FAIL abort_restart: got %0d cycles final %h want 5 cycles final 042", cyc, finalAddr);
        end
    endtask

    task automatic test_back_to_back;
        int          cyc, n, wt, lat;
        bit          ok;
        logic        ld;
        logic [7:0]  mask;
        logic [11:0] base;
        for (int t = 0; t < 6; t++) begin
            ld   = t[0];
            mask = 8'($urandom_range(1, 255));
            base = 12'($urandom);
            wt   = (t < 3) ? 0 : int'($urandom_range(0, 2));
            n    = $countones(mask);
            lat  = ld ? n * (3 + wt) + 1 : n * (2 + wt) + 1;
            start_op(ld, base, mask, wt, 1'b0);
            wait_done(cyc, ok);
            checks++;
            if (!ok || cyc != lat) begin
                errors++;
                $display("FAIL b2b_latency[%0d]: got %0d cycles (done %b) want %0d", t, cyc, ok, lat);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) regfile[i] = 16'($urandom);
        test_reset();
        test_stm_basic();
        test_ldm_wait();
        test_empty_mask();
        test_wrap();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(posedge clk);
        checks++;
        if (acc_q.size() != 0 || wb_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL drain: acc %0d wb %0d done %0d left want 0", acc_q.size(), wb_q.size(), done_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
Multicycle sequencer for the LDM/STM (load/store multiple) instructions of the processor. The main controller hands over base address, register mask and direction. The block walks the mask from the lowest register to the highest and issues one memory access per set bit, with a ready handshake to memory. Load data is written back through the register-file write port, and the end address is returned so the base register can be updated.

Parameters:
ADDR_W, 12, memory address width; addresses wrap modulo 2^ADDR_W
DATA_W, 16, memory and register data width
NREGS, 8, register count and mask width; IDX_W = clog2(NREGS)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle request from main controller; sampled only in IDLE
isLoad  input  1  1 = LDM (mem->reg), 0 = STM (reg->mem); latched on start
baseAddr  input  ADDR_W  first access address; latched on start
regMask  input  NREGS  bit i set = transfer register i; latched on start
memReady  input  1  memory completes the current access this cycle
memRdData  input  DATA_W  read data, valid when memReady=1 during a read
regRdData  input  DATA_W  register-file read data for regIdx (combinational)
memAddr  output  ADDR_W  current access address
memWrData  output  DATA_W  equals regRdData while memWrite=1, else 0
memRead  output  1  read request
memWrite  output  1  write request
regIdx  output  IDX_W  register currently addressed
regWrData  output  DATA_W  captured load data
regWrite  output  1  one-cycle register write strobe
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
finalAddr  output  ADDR_W  baseAddr + popcount(regMask) mod 2^ADDR_W; held from DONE until next start

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0, all internal registers 0. Any operation in progress is abandoned immediately and no further strobe is issued.
- States: IDLE, SCAN, ACCESS, WBACK, DONE. All control outputs are Moore outputs decoded from registered state. memWrData is the only combinational pass-through.
- IDLE: on start=1, latch isLoad, baseAddr into curAddr, and regMask into pending. Go to SCAN if regMask != 0, else go to DONE.
- SCAN (1 cycle): regIdx <= index of the lowest set bit of pending. Go to ACCESS.
- ACCESS: memAddr=curAddr. memRead=isLoad and memWrite=~isLoad, held stable until memReady=1. Zero-wait memory is allowed, so the minimum ACCESS length is 1 cycle.
  - memReady with load: regWrData <= memRdData, go to WBACK.
  - memReady with store: clear pending[regIdx], curAddr <= curAddr+1. Go to SCAN if remaining pending != 0, else go to DONE.
- WBACK (1 cycle): regWrite=1 with the current regIdx and regWrData. Clear pending[regIdx], curAddr <= curAddr+1. Go to SCAN or DONE on the same rule as a store.
- DONE (1 cycle): done=1, finalAddr=curAddr. Go to IDLE.
- start while busy=1 is ignored; no queueing.
- memReady outside ACCESS is ignored.
- memRead and memWrite are never high together.
- regWrite is never high outside WBACK.
- Address arithmetic is ADDR_W bits wide; 0xFFF+1 wraps to 0x000 with no error indication.
- Latency from start edge, with memReady tied to 1:
  - STM: 2 cycles per register, plus 1 cycle for DONE.
  - LDM: 3 cycles per register, plus 1 cycle for DONE.
  - Empty mask: done in the first cycle after start.

Test Plan:
1. Reset: drive rst=0 mid-simulation, asynchronously to clk -> all outputs 0 within the same cycle; busy=0; a subsequent start behaves as from a clean IDLE.
2. STM, base=0x010, mask=8'b0000_0101, memReady=1 -> memWrite at 0x010 with regIdx=0, then at 0x011 with regIdx=2. memWrData follows regRdData. done pulses 5 cycles after start. finalAddr=0x012.
3. LDM, base=0x0FF, mask=8'b1000_0001, memReady delayed 2 cycles per access -> memRead held 3 cycles at each of 0x0FF and 0x100. regWrite pulses with regIdx=0, then regIdx=7, each carrying memRdData. finalAddr=0x101.
4. Empty mask 0x00 -> done high exactly in cycle 1 after start; memRead, memWrite and regWrite never asserted; finalAddr=baseAddr.
5. Wrap: STM, base=0xFFF, mask=0x03 -> accesses at 0xFFF then 0x000; finalAddr=0x001.
6. Abort/ignore:
   - Second start during ACCESS -> ignored; mask sequence unchanged.
   - rst=0 during ACCESS of an LDM -> memRead drops immediately and no regWrite occurs.
